mul_seq_32: RTL and testbench

MUL_SEQ_32 -- requirements
Module: mul_seq_32

---
 rtl/mul_seq_32.sv | 95 +++++++++
 tb/tb_mul_seq_32.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_seq_32 : 32x32 unsigned shift-and-add multiplier, one step per clock
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mul_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        zero,
  output logic [5:0]  cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] product_q, product_d;
  logic [5:0]  cycles_q, cycles_d;
  logic        mplier_zero;

  assign mplier_zero = ~(|mplier_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      product_q <= 64'd0;
      cycles_q  <= 6'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cycles_q  <= cycles_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cycles_d  = cycles_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = {32'd0, a};
          mplier_d  = b;
          product_d = 64'd0;
          cycles_d  = 6'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Finishing once the remaining multiplier is empty skips leading zeros of b.
        if (mplier_zero) begin
          state_d = DONE;
        end else begin
          if (mplier_q[0]) begin
            product_d = product_q + mcand_q;
          end
          mcand_d  = {mcand_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
          cycles_d = cycles_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign zero    = ~(|product_q);
  assign cycles  = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_seq_32 : self-checking bench for mul_seq_32 against an arithmetic model
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_mul_seq_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        zero;
  logic [5:0]  cycles;

  int total = 0;
  int bad   = 0;

  mul_seq_32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zero    (zero),
    .cycles  (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_steps(input logic [31:0] bv);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (bv[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [63:0] model_prod(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] x;
    logic [63:0] y;
    x = {32'd0, av};
    y = {32'd0, bv};
    return x * y;
  endfunction

  // Launch one operation, optionally disturbing a/b/start while it runs,
  // and check latency and results; returns with the DUT in IDLE-after-DONE.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit scramble);
    logic [63:0] ep;
    int          en;
    int          lat;
    bit          got;
    ep = model_prod(av, bv);
    en = model_steps(bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    check_val("busy_after_accept", {63'd0, busy}, 64'd1);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (scramble) begin
        a = $urandom; b = $urandom; start = $urandom_range(0, 1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat = k;
      if (done) got = 1'b1;
    end
    check_val("done_seen", {63'd0, got}, 64'd1);
    check_val("latency", lat, en + 1);
    check_val("product", product, ep);
    check_val("cycles", {58'd0, cycles}, en);
    check_val("zero", {63'd0, zero}, {63'd0, (ep == 64'd0)});
    check_val("busy_in_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check_val("idle_after_done", {62'd0, busy, done}, 64'd0);
    check_val("product_hold", product, ep);
  endtask

  initial begin
    logic [31:0] rb;
    bit          got;

    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    check_val("reset_outputs", {busy, done, zero, cycles}, {1'b0, 1'b0, 1'b1, 6'd0});
    check_val("reset_product", product, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'h12345678, 32'd0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(32'd2, 32'd2, 1'b0);
    run_op(32'd0, 32'd8, 1'b0);
    run_op(32'd1, 32'h80000000, 1'b0);

    // Held start with a/b changed mid-run: single op, then re-accept in IDLE
    @(negedge clk);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 32'd1; b = 32'd1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check_val("held_done_seen", {63'd0, got}, 64'd1);
    check_val("held_product", product, 64'd63);
    check_val("held_cycles", {58'd0, cycles}, 64'd4);
    @(posedge clk); #1;
    check_val("held_idle", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check_val("held_reaccept_busy", {63'd0, busy}, 64'd1);
    check_val("held_reaccept_clear", product, 64'd0);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check_val("reaccept_done_seen", {63'd0, got}, 64'd1);
    check_val("reaccept_product", product, 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset mid-run
    @(negedge clk);
    a = 32'd5; b = 32'h80000000; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("abort_outputs", {busy, done, zero, cycles}, {1'b0, 1'b0, 1'b1, 6'd0});
    check_val("abort_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) got = 1'b1;
    end
    check_val("abort_no_done", {63'd0, got}, 64'd0);

    // Randomized operations, some with inputs disturbed during the run
    for (int t = 0; t < 30; t++) begin
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op($urandom, rb, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
